// File: rtl/mem_responder.sv
// mem_responder: word memory answering control-unit requests with a fixed
// latency, a one-cycle MEM_rdy pulse and a one-cycle MEM_err pulse for illegal addresses.
`default_nettype none

module mem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_req,
  input  logic        MEM_w,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic [31:0] MEM_rdata,
  output logic        MEM_rdy,
  output logic        MEM_err,
  output logic        MEM_busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            w_q, w_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [DEPTH];

  logic [AW-1:0]   addr_idx;
  logic [AW-1:0]   rd_idx;
  logic            legal;

  assign addr_idx = MEM_addr[AW+1:2];
  assign legal    = (MEM_addr[1:0] == 2'b00) && ((MEM_addr >> (AW + 2)) == 32'd0);
  // With LAT = 1 DONE is entered straight from IDLE, so the index is still on the bus.
  assign rd_idx   = (state_q == S_IDLE) ? addr_idx : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MEM_req) begin
          if (legal) begin
            w_d     = MEM_w;
            idx_d   = addr_idx;
            wdata_d = MEM_wdata;
            cnt_d   = 3'(LAT - 1);
            if (LAT == 1) state_d = S_DONE;
            else          state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Leave on the edge where cnt reaches zero so DONE lands in cycle T+LAT.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      w_q     <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if ((state_d == S_DONE) && !w_d) rdata_q <= mem_q[rd_idx];
    end
  end

  // Array has no reset; a write held in DONE is dropped if reset lands on its commit edge.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_DONE) && w_q) mem_q[idx_q] <= wdata_q;
  end

  assign MEM_busy  = (state_q != S_IDLE);
  assign MEM_rdy   = (state_q == S_DONE);
  assign MEM_err   = err_q;
  assign MEM_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LAT=3 and LAT=1 builds share one random/directed stimulus
// stream and are compared every cycle against a transaction-level model.
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        w;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata3, rdata1;
  logic        rdy3, rdy1, err3, err1, busy3, busy1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] init_vals [16];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .LAT(3)) dut3 (
    .clk(clk), .reset(rst_n), .MEM_req(req), .MEM_w(w), .MEM_addr(addr),
    .MEM_wdata(wdata), .MEM_rdata(rdata3), .MEM_rdy(rdy3), .MEM_err(err3),
    .MEM_busy(busy3)
  );

  mem_responder #(.DEPTH(256), .LAT(1)) dut1 (
    .clk(clk), .reset(rst_n), .MEM_req(req), .MEM_w(w), .MEM_addr(addr),
    .MEM_wdata(wdata), .MEM_rdata(rdata1), .MEM_rdy(rdy1), .MEM_err(err1),
    .MEM_busy(busy1)
  );

  // Reference model: each accepted request owns the next LAT cycles; the last of them
  // carries the ready pulse, and a write lands in the array as that cycle ends.
  int          lat_of [2] = '{3, 1};
  int          m_left [2] = '{0, 0};
  logic        m_pw   [2] = '{1'b0, 1'b0};
  int          m_pidx [2] = '{0, 0};
  logic [31:0] m_pd   [2] = '{32'd0, 32'd0};
  logic        e_busy [2] = '{1'b0, 1'b0};
  logic        e_rdy  [2] = '{1'b0, 1'b0};
  logic        e_err  [2] = '{1'b0, 1'b0};
  logic [31:0] e_rdata[2] = '{32'd0, 32'd0};
  logic [31:0] mmem   [2][256];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k]  = 0;
        e_busy[k]  = 1'b0;
        e_rdy[k]   = 1'b0;
        e_err[k]   = 1'b0;
        e_rdata[k] = 32'd0;
      end else begin
        e_err[k] = 1'b0;
        if (m_left[k] > 0) begin
          if (m_left[k] == 1 && m_pw[k]) mmem[k][m_pidx[k]] = m_pd[k];
          m_left[k] = m_left[k] - 1;
        end else if (req) begin
          if ((addr % 4) == 0 && (addr / 4) < 256) begin
            m_left[k] = lat_of[k];
            m_pw[k]   = w;
            m_pidx[k] = int'(addr / 4);
            m_pd[k]   = wdata;
          end else begin
            e_err[k] = 1'b1;
          end
        end
        e_busy[k] = (m_left[k] > 0);
        e_rdy[k]  = (m_left[k] == 1);
        if (e_rdy[k] && !m_pw[k]) e_rdata[k] = mmem[k][m_pidx[k]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("lat3_busy",  {31'd0, busy3}, {31'd0, e_busy[0]});
      check("lat3_rdy",   {31'd0, rdy3},  {31'd0, e_rdy[0]});
      check("lat3_err",   {31'd0, err3},  {31'd0, e_err[0]});
      check("lat3_rdata", rdata3,         e_rdata[0]);
      check("lat1_busy",  {31'd0, busy1}, {31'd0, e_busy[1]});
      check("lat1_rdy",   {31'd0, rdy1},  {31'd0, e_rdy[1]});
      check("lat1_err",   {31'd0, err1},  {31'd0, e_err[1]});
      check("lat1_rdata", rdata1,         e_rdata[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request followed by enough idle cycles for both builds to finish.
  task automatic req1(input logic wr, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; w = wr; addr = a; wdata = d;
    step();
    req = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int r;
    rst_n = 1'b0; req = 1'b1; w = 1'b0; addr = 32'd0; wdata = 32'd0;
    step();
    chk_en = 1'b1;
    step();
    check("rst_busy3", {31'd0, busy3}, 32'd0);
    check("rst_rdata3", rdata3, 32'd0);
    rst_n = 1'b1; req = 1'b0;
    repeat (3) step();
    check("idle_busy3", {31'd0, busy3}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      init_vals[i] = $urandom;
      req1(1'b1, 32'(i * 4), init_vals[i]);
    end

    // Write then read back one word.
    req1(1'b1, 32'h10, 32'hDEADBEEF);
    req1(1'b0, 32'h10, 32'd0);
    check("wr_rd_lat3", rdata3, 32'hDEADBEEF);
    check("wr_rd_lat1", rdata1, 32'hDEADBEEF);

    // Misaligned read, then out-of-range write.
    req1(1'b0, 32'h13, 32'd0);
    check("misalign_hold", rdata3, 32'hDEADBEEF);
    req1(1'b1, 32'h400, 32'hA5A5A5A5);
    req1(1'b0, 32'h0, 32'd0);
    check("oor_word0", rdata3, init_vals[0]);

    // Request held during busy; next acceptance at T+LAT+1.
    req = 1'b1; w = 1'b0; addr = 32'h4; wdata = 32'd0;
    step();
    w = 1'b1; addr = 32'h8; wdata = 32'h0BADF00D;
    repeat (3) step();
    w = 1'b0; addr = 32'h8;
    step();
    req = 1'b0;
    repeat (4) step();
    check("busy_ign_w8", rdata3, init_vals[2]);
    check("lat1_took_w8", rdata1, 32'h0BADF00D);

    // Reset while a write is in flight.
    req = 1'b1; w = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    step();
    req = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    req1(1'b0, 32'h20, 32'd0);
    check("rst_mid_wr", rdata3, init_vals[8]);
    check("lat1_committed", rdata1, 32'h12345678);

    // Back-to-back reads, two cycles apart.
    req = 1'b1; w = 1'b0; addr = 32'h0;
    step();
    req = 1'b0;
    step();
    req = 1'b1; addr = 32'h4;
    step();
    req = 1'b0;
    repeat (4) step();
    check("b2b_lat1", rdata1, init_vals[1]);
    check("b2b_lat3", rdata3, init_vals[0]);

    for (int n = 0; n < 400; n++) begin
      rst_n = (($urandom % 64) != 0);
      req   = 1'($urandom % 2);
      w     = 1'($urandom % 2);
      r     = int'($urandom % 8);
      if (r == 0)      addr = 32'h400 | $urandom;
      else if (r == 1) addr = 32'(($urandom % 16) * 4 + 1 + ($urandom % 3));
      else             addr = 32'(($urandom % 16) * 4);
      wdata = $urandom;
      step();
    end
    rst_n = 1'b1; req = 1'b0;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Multicycle word memory that answers the control unit's memory requests with a fixed, parameterized latency and a one-cycle ready pulse. It is the responder for the MEM_w/address/data interface the control unit drives during fetch (PC → IR) and load/store states. With the handshake, the control unit waits for MEM_rdy instead of counting wait cycles. It sits between the control unit and the address/data muxes, replacing the bare RAM instance.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words stored; must be a power of two, ≥ 4.
- LAT, 3: read/write latency in cycles, from request sample to MEM_rdy; legal range 1–7.

Ports:
- clk  in  1  system clock; all activity on posedge.
- reset  in  1  reset; synchronous, active-low (0 = reset, sampled on posedge).
- MEM_req  in  1  request strobe from the control unit; sampled only when MEM_busy = 0.
- MEM_w  in  1  1 = write, 0 = read; sampled with MEM_req.
- MEM_addr  in  32  byte address; sampled with MEM_req.
- MEM_wdata  in  32  write data; sampled with MEM_req.
- MEM_rdata  out  32  read data; valid while MEM_rdy = 1 and held until the next accepted read.
- MEM_rdy  out  1  one-cycle completion pulse for an accepted, legal request.
- MEM_err  out  1  one-cycle pulse for an illegal request (misaligned or out of range).
- MEM_busy  out  1  request in flight; new requests are ignored while high.

## Operation
- Storage: DEPTH × 32-bit array, word index = MEM_addr[log2(DEPTH)+1:2]. Contents are not cleared by reset. Initial contents come from simulation preload only.
- Legal request: MEM_addr[1:0] = 2'b00 and (MEM_addr >> 2) < DEPTH. Anything else is illegal.
- States:
  - IDLE: MEM_busy = 0. On a posedge with MEM_req = 1:
    - legal request → latch w, index, wdata; load cnt = LAT−1; go to WAIT.
    - illegal request → pulse MEM_err next cycle, stay in IDLE, no array access, MEM_rdata unchanged.
  - WAIT: MEM_busy = 1. Decrement cnt each cycle. When cnt = 0 → DONE.
  - DONE: MEM_busy = 1, MEM_rdy = 1.
    - Read: MEM_rdata = array[index].
    - Write: array[index] ← latched wdata, committed at the posedge that ends DONE.
    - MEM_rdata is unchanged by writes.
    - Next state: IDLE.
- When LAT = 1, WAIT is skipped: IDLE → DONE directly.
- MEM_req while MEM_busy = 1 is ignored. It is not queued and does not set MEM_err.
- Read-after-write to the same word, issued after the write's MEM_rdy, returns the new data.
- Reset mid-operation (any state): go to IDLE and drop the in-flight request. A pending write is not committed. The array is otherwise untouched.

## Timing
- Reset values: MEM_rdata = 0, MEM_rdy = 0, MEM_err = 0, MEM_busy = 0, state = IDLE, cnt = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Define T as the cycle in which MEM_req = 1 is sampled with MEM_busy = 0.
  - Legal request: MEM_busy = 1 in cycles T+1 … T+LAT; MEM_rdy = 1 in cycle T+LAT only.
  - Illegal request: MEM_err = 1 in cycle T+1 only; MEM_busy stays 0.
- The earliest next acceptance after a legal request is cycle T+LAT+1, giving a throughput of one request per LAT+1 cycles.
- The earliest next acceptance after an illegal request is cycle T+1.
- MEM_rdy and MEM_err are never high in the same cycle.
- A write is visible to a read accepted in cycle T+LAT+1 or later.

## Test plan
- Reset/defaults: hold reset = 0 for 2 cycles with MEM_req = 1 → all outputs 0 and no request accepted. Release reset → MEM_busy stays 0 until MEM_req.
- Write then read, LAT = 3: write 0xDEADBEEF to 0x0000_0010 in cycle T → MEM_busy high T+1..T+3, MEM_rdy in T+3. Then read 0x10 at T+4 → MEM_rdy in T+7 with MEM_rdata = 0xDEADBEEF, and MEM_rdata holds that value after T+7.
- Illegal requests: read 0x0000_0013 → MEM_err pulse next cycle, no MEM_rdy, MEM_rdata unchanged. Write 0x0000_0400 with DEPTH = 256 → MEM_err pulse, and a later read of word 0 still returns its prior value.
- Busy ignore: accept a read of 0x4, then hold MEM_req = 1 with MEM_w = 1 to 0x8 during busy → exactly one MEM_rdy; word 0x8 unchanged; the next request is accepted at T+LAT+1.
- Reset mid-write: accept a write of 0x12345678 to 0x20, assert reset in cycle T+2 → no MEM_rdy. A subsequent read of 0x20 returns its old value.
- LAT = 1 build: back-to-back legal reads of 0x0 and 0x4 → MEM_rdy in T+1 and T+3; MEM_busy is never high for two consecutive cycles.
